// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: control encodings,
// FSM state type and the lane/offset legality check used by DMEM_ERR_EN.
package dmem_responder_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam int          RegBus      = 32;

  typedef enum logic [1:0] {
    DmemIdle = 2'd0,
    DmemBusy = 2'd1,
    DmemDone = 2'd2
  } dmem_state_e;

  // True when the byte-lane pattern cannot be produced by an aligned access
  // at byte offset off (big-endian lanes: sel[3] is offset 0).
  function automatic logic lane_err(input logic [3:0] sel, input logic [1:0] off);
    logic bad;
    case (sel)
      4'b0000: bad = 1'b1;
      4'b1111: bad = (off != 2'b00);
      4'b1100: bad = (off != 2'b00);
      4'b0011: bad = (off != 2'b10);
      4'b1000: bad = (off != 2'b00);
      4'b0100: bad = (off != 2'b01);
      4'b0010: bad = (off != 2'b10);
      4'b0001: bad = (off != 2'b11);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with four byte-lane write enables. Writes are
// synchronous; the read port is asynchronous so the responder can capture
// the word on the same edge that completes the access.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [RegBus-1:0] mem [DEPTH];

  // Byte-lane masked write; lane k covers bits 8k+7:8k.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store interface.
// Latches one request, waits WAIT_CYCLES, performs the array access, then
// pulses ack_o for one cycle. stall_o holds the pipeline while in flight.
// Optional macro DMEM_ERR_EN adds err_o and address/lane legality checks.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o
`ifdef DMEM_ERR_EN
  ,
  output logic        err_o
`endif
);

  dmem_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic              req_we_p0;
  logic [ADDR_W-1:0] req_idx_p0;
  logic [3:0]        req_sel_p0;
  logic [31:0]       req_data_p0;
  logic              req_err_p0;
  logic              req_err_now;
  logic              access_now;
  logic              bank_we;
  logic [31:0]       bank_rdata;

`ifdef DMEM_ERR_EN
  assign req_err_now = ((addr_i >> (ADDR_W + 2)) != 32'd0) || lane_err(sel_i, addr_i[1:0]);
`else
  // Upper address bits alias and the byte offset is not used by the array.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign req_err_now = 1'b0;
`endif

  assign access_now = (state == DmemBusy) && (cnt == '0);
  assign bank_we    = access_now && (req_we_p0 == WriteEnable) && !req_err_p0
                      && (rst != RstEnable);

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (req_sel_p0),
    .addr  (req_idx_p0),
    .wdata (req_data_p0),
    .rdata (bank_rdata)
  );

  // Request FSM: accept in IDLE, count wait states in BUSY, ack in DONE.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state       <= DmemIdle;
      cnt         <= '0;
      ack_o       <= 1'b0;
      data_o      <= ZeroWord;
      req_we_p0   <= 1'b0;
      req_idx_p0  <= '0;
      req_sel_p0  <= '0;
      req_data_p0 <= ZeroWord;
      req_err_p0  <= 1'b0;
`ifdef DMEM_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
`ifdef DMEM_ERR_EN
      err_o <= 1'b0;
`endif
      case (state)
        DmemIdle: begin
          if (ce_i == ChipEnable) begin
            req_we_p0   <= we_i;
            req_idx_p0  <= addr_i[ADDR_W+1:2];
            req_sel_p0  <= sel_i;
            req_data_p0 <= data_i;
            req_err_p0  <= req_err_now;
            cnt         <= CNT_W'(WAIT_CYCLES);
            state       <= DmemBusy;
          end
        end
        DmemBusy: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DmemDone;
            ack_o <= 1'b1;
            if (req_we_p0 != WriteEnable) begin
              data_o <= req_err_p0 ? ZeroWord : bank_rdata;
            end
`ifdef DMEM_ERR_EN
            err_o <= req_err_p0;
`endif
          end
        end
        DmemDone: state <= DmemIdle;
        default:  state <= DmemIdle;
      endcase
    end
  end

  // Stall while a request is pending or being serviced; released in DONE.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      DmemIdle: stall_o = ce_i;
      DmemBusy: stall_o = 1'b1;
      default:  stall_o = 1'b0;
    endcase
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the MEM-stage load/store interface. Accepts one request (chip enable, write enable, byte-lane select, address, write data) from the MEM stage and services it from an internal word-organised RAM after a configurable number of wait states. While the access is in flight it asserts a stall request to the pipeline control. It returns read data on a held output bus, which the MEM stage lane-extracts combinationally.

Parameters:
ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words.
WAIT_CYCLES, 1, extra wait states inserted before the array access (0..15).
CNT_W, 4, width of the wait-state counter; must hold WAIT_CYCLES.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
ce_i  in  1  request valid (chip enable), held by requester until ack.
we_i  in  1  1 = store, 0 = load.
addr_i  in  32  byte address; word index = addr_i[ADDR_W+1:2].
sel_i  in  4  byte-lane enables; sel_i[3] = bits 31:24 = byte offset 0 (big-endian lanes).
data_i  in  32  store data, already lane-replicated by the requester.
data_o  out  32  read data, registered, held until next completed load.
ack_o  out  1  one-cycle completion pulse.
stall_o  out  1  pipeline stall request, combinational.

Behaviour:
- Reset (synchronous): state=IDLE, data_o=0, ack_o=0, counter=0, latched request regs=0; stall_o evaluates to 0. RAM contents not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if ce_i=1, latch we/addr/sel/data, counter<=WAIT_CYCLES, go BUSY; stall_o=ce_i.
- BUSY: stall_o=1. If counter!=0, decrement it. If counter==0, perform the access and go DONE:
  - Store: for each lane k with sel[k]=1, write the corresponding byte of the latched data. Lanes with sel[k]=0 unchanged.
  - Load: data_o <= full word (sel ignored for reads).
- DONE: ack_o=1 (registered, set on the BUSY->DONE edge), stall_o=0, always go IDLE.
- ack_o is 0 in every other state.
- Latency: request seen in cycle t0. Access occurs at the end of cycle t0+1+WAIT_CYCLES. ack_o/valid data_o in cycle t0+2+WAIT_CYCLES. stall_o is high from t0 through t0+1+WAIT_CYCLES.
- Back-to-back: the next request can be accepted in the IDLE cycle following DONE. There is no acceptance in DONE.
- Request inputs changing or ce_i dropping during BUSY/DONE: ignored; the latched request completes.
- Store with sel=0000: no RAM change, still acks. Store never alters data_o.
- Address bits above ADDR_W+1 are ignored (aliasing) unless the optional feature is enabled. addr_i[1:0] is not used for the array access.
- Reset asserted in BUSY: access is dropped (no write) and the FSM goes to IDLE next cycle.

Optional Feature:
DMEM_ERR_EN: adds port err_o (out, 1).
- err_o is registered and valid only with ack_o. It is set in DONE when any of the following holds:
  - addr_i[31:ADDR_W+2] != 0
  - sel=0000
  - sel=1111 with addr[1:0] != 00
  - sel in {1100, 0011} with addr[1:0] not equal to 00 or 10 respectively
  - a single-bit sel that does not match addr[1:0]
- On error: a store is suppressed and a load returns data_o=0.
- Without the macro: no err_o port, no checks, aliasing as above.

Decomposition:
- Shared defines.v: RstEnable, ChipEnable, WriteEnable, ZeroWord, RegBus, plus new DmemIdle/DmemBusy/DmemDone state encodings.
- One natural sub-module: dmem_bank, a byte-enable synchronous RAM (4 byte lanes, DEPTH words, single port) instantiated by the FSM.

Test Plan:
- Reset then idle -> data_o=0, ack_o=0, stall_o=0. With WAIT_CYCLES=1, SW 0x11223344 to addr 0x10 -> stall_o high exactly 3 cycles, ack_o 1 cycle later. LW 0x10 -> data_o=0x11223344 at ack.
- SB with data_i=0xAAAAAAAA, sel=0100, addr 0x11 -> following LW 0x10 returns 0x11AA3344.
- SH with data_i=0xBEEFBEEF, sel=0011, addr 0x12 -> LW 0x10 returns 0x11AABEEF. Store with sel=0000 leaves the word unchanged and still acks.
- Back-to-back LW 0x10 then LW 0x14 with ce_i held -> two ack_o pulses separated by exactly WAIT_CYCLES+3 cycles. Changing addr_i during BUSY does not affect the returned word.
- rst pulsed in the BUSY cycle of SW 0xDEADBEEF to 0x20 -> no ack. Subsequent LW 0x20 returns the prior value, not 0xDEADBEEF.
- With DMEM_ERR_EN and ADDR_W=10: LW addr 0x00001000 -> err_o=1 with ack, data_o=0. SW sel=1111 to addr 0x22 -> err_o=1 and memory unchanged.
